servstolic_wb_arbiter: RTL and testbench

Round-robin Wishbone arbiter that lets the NM serv cores of the servstolic grid share one Wishbone slave (shared RAM, UART or GPIO). Each core is a Wishbone master; the arbiter grants exactly one at a time, holds the grant for the whole transaction and returns ack, error and read data. A per-transaction timeout counter terminates hung transactions with an error so one dead slave cannot deadlock the grid.

---
 rtl/servstolic_pkg.sv | 25 ++
 rtl/servstolic_rr_pick.sv | 38 +++
 rtl/servstolic_wb_arbiter.sv | 156 +++++++++++++++
 tb/tb_servstolic_wb_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servstolic_pkg.sv
// -----------------------------------------------------------------------------
// servstolic_pkg
// Shared types and constants for the servstolic Wishbone arbitration blocks.
//   state_t          : arbiter FSM state (ST_IDLE / ST_BUSY)
//   DEFAULT_NM       : default number of masters (16 cores)
//   DEFAULT_IW       : grant index width for DEFAULT_NM masters
//   DEFAULT_TIMEOUT  : default BUSY cycles without ack before an error
//   cnt_width()      : timeout counter width; a disabled timeout still gets 1 bit
// -----------------------------------------------------------------------------
package servstolic_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_BUSY = 1'b1;

  localparam int DEFAULT_NM      = 16;
  localparam int DEFAULT_IW      = $clog2(DEFAULT_NM);
  localparam int DEFAULT_TIMEOUT = 255;

  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/servstolic_rr_pick.sv
// -----------------------------------------------------------------------------
// servstolic_rr_pick
// Purely combinational round-robin picker. Starting at last+1 and wrapping
// modulo NM, returns the first set bit of req.
//   req   in  NM  request vector
//   last  in  IW  index served most recently
//   valid out 1   at least one request is present
//   idx   out IW  chosen requester (equals last when valid is low)
// -----------------------------------------------------------------------------
module servstolic_rr_pick
  import servstolic_pkg::*;
#(
  parameter int NM = DEFAULT_NM,
  parameter int IW = $clog2(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan offsets from farthest to nearest so the nearest requester after last overwrites the rest.
  always_comb begin
    int pos;
    pos   = 0;
    valid = |req;
    idx   = last;
    for (int off = NM; off >= 1; off--) begin
      pos = (int'(last) + off) % NM;
      if (req[pos]) begin
        idx = IW'(pos);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/servstolic_wb_arbiter.sv
// -----------------------------------------------------------------------------
// servstolic_wb_arbiter
// Round-robin Wishbone arbiter: NM masters share one slave. One grant at a
// time, held for the whole transaction; a timeout turns a hung slave into an
// error so the grid cannot deadlock.
//   wb_clk, wb_rst        clock, asynchronous active-high reset
//   i_m_cyc/we [NM]       per-master cycle / write enable
//   i_m_adr/dat/sel       per-master request fields, master k at [k*W +: W]
//   o_m_rdt [DW]          slave read data broadcast to all masters
//   o_m_ack/err [NM]      one-hot completion to the granted master
//   o_s_cyc/we/adr/dat/sel  slave request
//   i_s_rdt, i_s_ack      slave response
//   o_grant [IW]          current or last granted master
//   o_busy                high while a transaction is owned
// -----------------------------------------------------------------------------
module servstolic_wb_arbiter
  import servstolic_pkg::*;
#(
  parameter int NM      = DEFAULT_NM,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int IW      = $clog2(NM)
) (
  input  logic                wb_clk,
  input  logic                wb_rst,
  input  logic [NM-1:0]       i_m_cyc,
  input  logic [NM-1:0]       i_m_we,
  input  logic [NM*AW-1:0]    i_m_adr,
  input  logic [NM*DW-1:0]    i_m_dat,
  input  logic [NM*DW/8-1:0]  i_m_sel,
  output logic [DW-1:0]       o_m_rdt,
  output logic [NM-1:0]       o_m_ack,
  output logic [NM-1:0]       o_m_err,
  output logic                o_s_cyc,
  output logic                o_s_we,
  output logic [AW-1:0]       o_s_adr,
  output logic [DW-1:0]       o_s_dat,
  output logic [DW/8-1:0]     o_s_sel,
  input  logic [DW-1:0]       i_s_rdt,
  input  logic                i_s_ack,
  output logic [IW-1:0]       o_grant,
  output logic                o_busy
);

  localparam int SW = DW / 8;
  localparam int CW = cnt_width(TIMEOUT);

  state_t        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q,  last_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;

  logic busy;
  logic cyc_g;
  logic to_hit;
  logic ack_fire;
  logic err_fire;
  logic done;

  servstolic_rr_pick #(
    .NM (NM),
    .IW (IW)
  ) u_pick (
    .req   (i_m_cyc),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Decode the completion events of the owned transaction.
  always_comb begin
    busy     = (state_q == ST_BUSY);
    cyc_g    = i_m_cyc[grant_q];
    to_hit   = busy && (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));
    ack_fire = busy && i_s_ack;
    // ack beats timeout; a master that has already dropped cyc gets nothing.
    err_fire = to_hit && !i_s_ack && cyc_g;
    done     = ack_fire || err_fire || !cyc_g;
  end

  // FSM next state, grant capture and saturating timeout counter.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_BUSY;
          grant_d = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (done) begin
          state_d = ST_IDLE;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; last starts at NM-1 so master 0 has first priority.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NM - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Slave field mux and one-hot ack/err demux back to the granted master.
  always_comb begin
    o_s_we  = i_m_we[grant_q];
    o_s_adr = i_m_adr[int'(grant_q)*AW +: AW];
    o_s_dat = i_m_dat[int'(grant_q)*DW +: DW];
    o_s_sel = i_m_sel[int'(grant_q)*SW +: SW];
    o_s_cyc = busy && cyc_g && !err_fire;
    o_m_rdt = i_s_rdt;
    o_grant = grant_q;
    o_busy  = busy;
    o_m_ack = '0;
    o_m_err = '0;
    if (ack_fire) begin
      o_m_ack[grant_q] = 1'b1;
    end else begin
      o_m_ack = '0;
    end
    if (err_fire) begin
      o_m_err[grant_q] = 1'b1;
    end else begin
      o_m_err = '0;
    end
  end

endmodule

// File: tb/tb_servstolic_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_servstolic_wb_arbiter
// Directed scenarios followed by randomized traffic, checked every cycle
// against a transaction-level reference model (owner / elapsed cycles / last).
// -----------------------------------------------------------------------------
module tb_servstolic_wb_arbiter;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;
  localparam int IW = 2;

  logic              wb_clk = 1'b0;
  logic              wb_rst;
  logic [NM-1:0]     i_m_cyc;
  logic [NM-1:0]     i_m_we;
  logic [NM*AW-1:0]  i_m_adr;
  logic [NM*DW-1:0]  i_m_dat;
  logic [NM*SW-1:0]  i_m_sel;
  logic [DW-1:0]     o_m_rdt;
  logic [NM-1:0]     o_m_ack;
  logic [NM-1:0]     o_m_err;
  logic              o_s_cyc;
  logic              o_s_we;
  logic [AW-1:0]     o_s_adr;
  logic [DW-1:0]     o_s_dat;
  logic [SW-1:0]     o_s_sel;
  logic [DW-1:0]     i_s_rdt;
  logic              i_s_ack;
  logic [IW-1:0]     o_grant;
  logic              o_busy;

  int tests;
  int fails;

  // reference model: who owns the slave, how long, who was served last
  int m_owner;
  int m_cnt;
  int m_last;
  int m_grant;

  logic          e_busy;
  logic          e_scyc;
  logic [NM-1:0] e_ack;
  logic [NM-1:0] e_err;

  servstolic_wb_arbiter #(
    .NM      (NM),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TO)
  ) dut (
    .wb_clk  (wb_clk),
    .wb_rst  (wb_rst),
    .i_m_cyc (i_m_cyc),
    .i_m_we  (i_m_we),
    .i_m_adr (i_m_adr),
    .i_m_dat (i_m_dat),
    .i_m_sel (i_m_sel),
    .o_m_rdt (o_m_rdt),
    .o_m_ack (o_m_ack),
    .o_m_err (o_m_err),
    .o_s_cyc (o_s_cyc),
    .o_s_we  (o_s_we),
    .o_s_adr (o_s_adr),
    .o_s_dat (o_s_dat),
    .o_s_sel (o_s_sel),
    .i_s_rdt (i_s_rdt),
    .i_s_ack (i_s_ack),
    .o_grant (o_grant),
    .o_busy  (o_busy)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_last  = NM - 1;
    m_grant = 0;
  endtask

  task automatic model_expect();
    e_busy = (m_owner >= 0);
    e_scyc = 1'b0;
    e_ack  = '0;
    e_err  = '0;
    if (m_owner >= 0) begin
      if (i_s_ack) e_ack[m_owner] = 1'b1;
      else if (m_cnt == TO && i_m_cyc[m_owner]) e_err[m_owner] = 1'b1;
      e_scyc = i_m_cyc[m_owner] && (e_err == '0);
    end
  endtask

  task automatic model_edge();
    model_expect();
    if (wb_rst) begin
      model_reset();
    end else if (m_owner >= 0) begin
      if (e_ack != '0 || e_err != '0 || !i_m_cyc[m_owner]) m_owner = -1;
      else m_cnt++;
    end else if (i_m_cyc != '0) begin
      for (int k = 1; k <= NM; k++) begin
        if (i_m_cyc[(m_last + k) % NM]) begin
          m_owner = (m_last + k) % NM;
          break;
        end
      end
      m_last  = m_owner;
      m_grant = m_owner;
      m_cnt   = 0;
    end
  endtask

  // called at posedge+1; compares outputs at posedge+4
  task automatic chk_cycle();
    #3;
    model_expect();
    check("busy",  o_busy,  e_busy);
    check("s_cyc", o_s_cyc, e_scyc);
    check("m_ack", o_m_ack, e_ack);
    check("m_err", o_m_err, e_err);
    check("grant", o_grant, m_grant);
    check("m_rdt", o_m_rdt, i_s_rdt);
    if (e_busy) begin
      check("s_we",  o_s_we,  i_m_we[m_owner]);
      check("s_adr", o_s_adr, i_m_adr[m_owner*AW +: AW]);
      check("s_dat", o_s_dat, i_m_dat[m_owner*DW +: DW]);
      check("s_sel", o_s_sel, i_m_sel[m_owner*SW +: SW]);
    end
  endtask

  task automatic adv();
    @(posedge wb_clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    wb_rst = 1'b1;
    model_reset();
    chk_cycle();
    check("rst_busy", o_busy, 1'b0);
    check("rst_grant", o_grant, 2'd0);
    adv();
    wb_rst = 1'b0;
  endtask

  initial begin
    logic       seq_busy [0:9];
    logic [1:0] seq_grant[0:9];
    int         err_at;
    logic [NM-1:0] err_val;

    tests = 0;
    fails = 0;
    model_reset();
    wb_rst  = 1'b1;
    i_m_cyc = '0;
    i_m_we  = '0;
    i_m_adr = '0;
    i_m_dat = '0;
    i_m_sel = '0;
    i_s_ack = 1'b0;
    i_s_rdt = '0;
    for (int k = 0; k < NM; k++) begin
      i_m_adr[k*AW +: AW] = 32'h1000_0000 + 32'(k);
      i_m_dat[k*DW +: DW] = 32'hA000_0000 + 32'(k);
      i_m_sel[k*SW +: SW] = 4'hF;
    end
    #1;
    apply_reset();

    // master 2 alone, zero-wait slave
    i_m_cyc = 4'b0100;
    i_s_ack = 1'b1;
    i_s_rdt = 32'hDEAD_BEEF;
    chk_cycle();
    adv();
    chk_cycle();
    check("t1_scyc",  o_s_cyc, 1'b1);
    check("t1_ack",   o_m_ack, 4'b0100);
    check("t1_rdt",   o_m_rdt, 32'hDEAD_BEEF);
    check("t1_grant", o_grant, 2'd2);
    adv();
    i_m_cyc = '0;
    chk_cycle();
    adv();

    // all four request continuously with zero-wait ack
    apply_reset();
    i_m_cyc = 4'b1111;
    i_s_ack = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk_cycle();
      seq_busy[c]  = o_busy;
      seq_grant[c] = o_grant;
      adv();
    end
    for (int c = 0; c < 10; c++) begin
      check("rr_busy", seq_busy[c], (c % 2 == 1));
      if (c % 2 == 1) check("rr_order", seq_grant[c], (c / 2) % NM);
    end
    i_m_cyc = '0;
    i_s_ack = 1'b0;
    chk_cycle();
    adv();

    // timeout: slave never acks; master 3 waits behind master 1
    apply_reset();
    i_m_cyc = 4'b1010;
    i_s_ack = 1'b0;
    chk_cycle();
    adv();
    err_at  = -1;
    err_val = '0;
    for (int n = 1; n <= 20; n++) begin
      chk_cycle();
      if (o_m_err != '0 && err_at < 0) begin
        err_at  = n;
        err_val = o_m_err;
      end
      adv();
      if (err_at >= 0) break;
    end
    check("to_cycle", 64'(err_at), 64'd9);
    check("to_onehot", err_val, 4'b0010);
    chk_cycle();
    check("to_idle", o_busy, 1'b0);
    adv();
    chk_cycle();
    check("to_next_busy",  o_busy,  1'b1);
    check("to_next_grant", o_grant, 2'd3);
    i_m_cyc = '0;
    adv();
    chk_cycle();
    adv();

    // ack arrives in the very cycle the counter reaches TIMEOUT
    apply_reset();
    i_m_cyc = 4'b0001;
    chk_cycle();
    adv();
    for (int n = 1; n <= TO; n++) begin
      chk_cycle();
      adv();
    end
    i_s_ack = 1'b1;
    chk_cycle();
    check("race_ack", o_m_ack, 4'b0001);
    check("race_err", o_m_err, 4'b0000);
    adv();
    i_s_ack = 1'b0;
    i_m_cyc = '0;
    chk_cycle();
    adv();

    // master 1 abandons mid-wait; master 2 is next
    apply_reset();
    i_m_cyc = 4'b0110;
    chk_cycle();
    adv();
    for (int n = 0; n < 3; n++) begin
      chk_cycle();
      adv();
    end
    i_m_cyc = 4'b0100;
    chk_cycle();
    check("ab_ack", o_m_ack, 4'b0000);
    check("ab_err", o_m_err, 4'b0000);
    adv();
    chk_cycle();
    check("ab_idle", o_busy, 1'b0);
    adv();
    chk_cycle();
    check("ab_next", o_grant, 2'd2);
    check("ab_busy", o_busy, 1'b1);
    i_m_cyc = '0;
    adv();

    // reset while BUSY
    chk_cycle();
    adv();
    i_m_cyc = 4'b1000;
    chk_cycle();
    adv();
    chk_cycle();
    check("mr_pre_busy", o_busy, 1'b1);
    wb_rst  = 1'b1;
    i_s_ack = 1'b1;
    model_reset();
    #1;
    check("mr_scyc", o_s_cyc, 1'b0);
    check("mr_ack",  o_m_ack, 4'b0000);
    check("mr_err",  o_m_err, 4'b0000);
    check("mr_busy", o_busy,  1'b0);
    @(posedge wb_clk);
    model_edge();
    #1;
    wb_rst  = 1'b0;
    i_m_cyc = 4'b1111;
    chk_cycle();
    adv();
    chk_cycle();
    check("mr_first", o_grant, 2'd0);
    i_m_cyc = '0;
    i_s_ack = 1'b0;
    adv();

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NM; k++) begin
        if ($urandom_range(0, 7) == 0) i_m_cyc[k] = ~i_m_cyc[k];
        i_m_we[k] = 1'($urandom_range(0, 1));
        i_m_adr[k*AW +: AW] = $urandom;
        i_m_dat[k*DW +: DW] = $urandom;
        i_m_sel[k*SW +: SW] = SW'($urandom_range(0, 15));
      end
      i_s_ack = ($urandom_range(0, 9) == 0);
      i_s_rdt = $urandom;
      wb_rst  = ($urandom_range(0, 199) == 0);
      if (wb_rst) model_reset();
      chk_cycle();
      adv();
    end
    wb_rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
